// File: rtl/hc595_frame_rx_if.sv
// Bundle for the 74HC595 receive monitor: the three-wire serial bus plus the
// recovered word, digit value, and status pulses.
// master: drives the serial bus and observes the results.
// slave:  the receiver, which samples the bus and drives the results.
interface hc595_frame_rx_if #(
  parameter int WORD_W = 15
);
  logic              ds;
  logic              shcp;
  logic              stcp;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic [31:0]       nums;
  logic [7:0]        digit_valid;
  logic              frame_done;
  logic              err_len;
  logic              err_sel;
  logic              err_seg;

  modport master (
    output ds, shcp, stcp,
    input  word, word_valid, nums, digit_valid, frame_done,
    input  err_len, err_sel, err_seg
  );

  modport slave (
    input  ds, shcp, stcp,
    output word, word_valid, nums, digit_valid, frame_done,
    output err_len, err_sel, err_seg
  );
endinterface

// File: rtl/hc595_frame_rx.sv
// Rebuilds latched 74HC595 words {led, sel} and decodes them back into the 32-bit nums value.
// Latency: word_valid is 3 clk after a raw stcp rise, and nums is 4 clk after it. Both are 2 clk more with the glitch filter.
// No backpressure: this is a passive monitor, and each event is reported by a one-cycle pulse.
// Ports: clk, rst_n (async active-low), and bus (hc595_frame_rx_if.slave).
//   Inputs are ds, shcp, stcp. Outputs are word, word_valid, nums, digit_valid,
//   frame_done, err_len, err_sel, err_seg.
// Optional macro HC595_RX_GLITCH_FILTER_EN: a shcp/stcp edge is accepted only once the
//   synchronized level has held for 2 further clk.
module hc595_frame_rx #(
  parameter int WORD_W         = 15,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  hc595_frame_rx_if.slave bus
);

  // 7-segment glyphs for 0..F, with bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Two-FF synchronizers. The bit order is {stcp, shcp, ds}.
  logic [2:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.stcp, bus.shcp, bus.ds};
      sync2 <= sync1;
    end
  end

  logic ds_s, sh_rise, st_rise;

`ifdef HC595_RX_GLITCH_FILTER_EN
  // A level is accepted once three consecutive synchronized samples agree.
  // ds is delayed by the same two cycles so that it stays aligned with shcp.
  logic [2:0] dly1, dly2;
  logic       sh_lvl, st_lvl, sh_lvl_c, st_lvl_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly1   <= '0;
      dly2   <= '0;
      sh_lvl <= 1'b0;
      st_lvl <= 1'b0;
    end else begin
      dly1   <= sync2;
      dly2   <= dly1;
      sh_lvl <= sh_lvl_c;
      st_lvl <= st_lvl_c;
    end
  end

  always_comb begin
    sh_lvl_c = sh_lvl;
    st_lvl_c = st_lvl;
    if (sync2[1] == dly1[1] && dly1[1] == dly2[1]) sh_lvl_c = sync2[1];
    if (sync2[2] == dly1[2] && dly1[2] == dly2[2]) st_lvl_c = sync2[2];
  end

  assign sh_rise = sh_lvl_c & ~sh_lvl;
  assign st_rise = st_lvl_c & ~st_lvl;
  assign ds_s    = dly2[0];
`else
  logic [2:1] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= sync2[2:1];
  end

  assign sh_rise = sync2[1] & ~prev[1];
  assign st_rise = sync2[2] & ~prev[2];
  assign ds_s    = sync2[0];
`endif

  // Shift register, bit count, and the storage (latch) stage.
  logic [WORD_W-1:0] sr, word_q;
  logic [4:0]        bit_cnt;
  logic              word_vld, err_len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      word_q    <= '0;
      bit_cnt   <= '0;
      word_vld  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      word_vld  <= st_rise;
      err_len_q <= st_rise && (bit_cnt != 5'd15);
      // The latch captures the pre-shift contents, as the real 595 does
      // when both clocks rise together.
      if (st_rise) word_q <= sr;
      if (sh_rise) sr <= {sr[WORD_W-2:0], ds_s};
      if (st_rise)
        bit_cnt <= sh_rise ? 5'd1 : 5'd0;
      else if (sh_rise && bit_cnt != 5'd31)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Decode the latched word: correct the polarity, then look up sel and seg.
  logic [7:0] sel_n;
  logic [6:0] seg;
  logic       sel_ok, seg_ok;
  logic [2:0] sel_idx;
  logic [3:0] seg_idx;

  always_comb begin
    sel_n   = SEL_ACTIVE_LOW ? ~word_q[7:0] : word_q[7:0];
    seg     = SEG_ACTIVE_LOW ? ~word_q[WORD_W-1:8] : word_q[WORD_W-1:8];
    sel_ok  = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
    sel_idx = '0;
    for (int i = 0; i < 8; i++)
      if (sel_n[i]) sel_idx = i[2:0];
    seg_ok  = 1'b0;
    seg_idx = '0;
    for (int g = 0; g < 16; g++)
      if (seg == GLYPH[g]) begin
        seg_ok  = 1'b1;
        seg_idx = g[3:0];
      end
  end

  // Digit accumulation. A completed frame clears digit_valid on the next
  // cycle, but a digit decoded on that same cycle is kept.
  logic [31:0] nums_q, nums_nx;
  logic [7:0]  digit_vld, dv_nx;
  logic        frame_done_c, err_sel_q, err_seg_q;

  assign frame_done_c = (digit_vld == 8'hFF);

  always_comb begin
    nums_nx = nums_q;
    dv_nx   = frame_done_c ? 8'h00 : digit_vld;
    if (word_vld && sel_ok && seg_ok) begin
      nums_nx[{sel_idx, 2'b00} +: 4] = seg_idx;
      dv_nx[sel_idx]                 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nums_q    <= '0;
      digit_vld <= '0;
      err_sel_q <= 1'b0;
      err_seg_q <= 1'b0;
    end else begin
      nums_q    <= nums_nx;
      digit_vld <= dv_nx;
      err_sel_q <= word_vld && !sel_ok;
      err_seg_q <= word_vld && sel_ok && !seg_ok;
    end
  end

  assign bus.word        = word_q;
  assign bus.word_valid  = word_vld;
  assign bus.nums        = nums_q;
  assign bus.digit_valid = digit_vld;
  assign bus.frame_done  = frame_done_c;
  assign bus.err_len     = err_len_q;
  assign bus.err_sel     = err_sel_q;
  assign bus.err_seg     = err_seg_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Directed bench for hc595_frame_rx. A transaction-level model predicts every output cycle by cycle.
module tb_hc595_frame_rx;
`ifdef HC595_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hc595_frame_rx_if bus_if();

  hc595_frame_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [6:0] gly [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Bus-level model: the shift register contents and bit count as seen on the wire.
  typedef struct {int cyc; logic [14:0] w; bit el;} ev_t;
  ev_t         evq[$];
  logic [14:0] m_sr = '0;
  int          m_cnt = 0;
  bit          model_on = 1'b0;

  task automatic model_latch();
    ev_t e;
    if (!model_on) return;
    e.cyc = cyc + LAT;
    e.w   = m_sr;
    e.el  = (m_cnt != 15);
    evq.push_back(e);
    m_cnt = 0;
  endtask

  task automatic model_shift(input logic b);
    if (!model_on) return;
    m_sr  = {m_sr[13:0], b};
    m_cnt = (m_cnt >= 31) ? 31 : m_cnt + 1;
  endtask

  // Display-level model: the decoded digits.
  logic [14:0] m_word = '0;
  logic [31:0] m_nums = '0;
  logic [7:0]  m_dv   = '0;

  task automatic model_decode(input logic [14:0] w, output bit esel, output bit eseg);
    logic [7:0] sel_n;
    logic [6:0] seg;
    int         d, g;
    sel_n = ~w[7:0];
    seg   = ~w[14:8];
    esel  = 1'b0;
    eseg  = 1'b0;
    d     = -1;
    g     = -1;
    if ($countones(sel_n) != 1) begin
      esel = 1'b1;
      return;
    end
    for (int i = 0; i < 8; i++) if (sel_n[i]) d = i;
    for (int k = 0; k < 16; k++) if (gly[k] == seg) g = k;
    if (g < 0) begin
      eseg = 1'b1;
      return;
    end
    m_nums[d*4 +: 4] = g[3:0];
    m_dv[d]          = 1'b1;
  endtask

  int fd_cnt = 0, el_cnt = 0, es_cnt = 0, eg_cnt = 0;

  // Per-cycle compare of every output against the model.
  initial begin
    ev_t e;
    bit  e_wv, e_el, e_es, e_eg, e_fd, dec_pend, clr_pend;
    dec_pend = 1'b0;
    clr_pend = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      e_wv = 1'b0;
      e_el = 1'b0;
      e_es = 1'b0;
      e_eg = 1'b0;
      if (clr_pend) begin
        m_dv     = 8'h00;
        clr_pend = 1'b0;
      end
      if (dec_pend) begin
        dec_pend = 1'b0;
        model_decode(m_word, e_es, e_eg);
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e        = evq.pop_front();
        m_word   = e.w;
        e_wv     = 1'b1;
        e_el     = e.el;
        dec_pend = 1'b1;
      end
      e_fd = (m_dv == 8'hFF);
      if (e_fd) clr_pend = 1'b1;
      check("word",        32'(bus_if.word),        32'(m_word));
      check("word_valid",  32'(bus_if.word_valid),  32'(e_wv));
      check("nums",        bus_if.nums,             m_nums);
      check("digit_valid", 32'(bus_if.digit_valid), 32'(m_dv));
      check("frame_done",  32'(bus_if.frame_done),  32'(e_fd));
      check("err_len",     32'(bus_if.err_len),     32'(e_el));
      check("err_sel",     32'(bus_if.err_sel),     32'(e_es));
      check("err_seg",     32'(bus_if.err_seg),     32'(e_eg));
      if (bus_if.frame_done === 1'b1) fd_cnt++;
      if (bus_if.err_len === 1'b1)    el_cnt++;
      if (bus_if.err_sel === 1'b1)    es_cnt++;
      if (bus_if.err_seg === 1'b1)    eg_cnt++;
    end
  end

  // Each bit drives ds 3 clk before the shcp rise, then holds shcp high 8 clk and low 8 clk.
  task automatic shift_bit(input logic b, input bit with_stcp);
    @(negedge clk);
    bus_if.ds = b;
    repeat (3) @(negedge clk);
    bus_if.shcp = 1'b1;
    if (with_stcp) begin
      bus_if.stcp = 1'b1;
      model_latch();
    end
    model_shift(b);
    repeat (8) @(negedge clk);
    bus_if.shcp = 1'b0;
    bus_if.stcp = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic latch(input logic [14:0] expw, input bit chk);
    @(negedge clk);
    bus_if.stcp = 1'b1;
    model_latch();
    repeat (LAT - 1) @(negedge clk);
    if (chk) check("lit_wv_early", 32'(bus_if.word_valid), 32'd0);
    @(negedge clk);
    if (chk) begin
      check("lit_wv_on_time", 32'(bus_if.word_valid), 32'd1);
      check("lit_word",       32'(bus_if.word),       32'(expw));
    end
    repeat (8 - LAT) @(negedge clk);
    bus_if.stcp = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [14:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) shift_bit(w[k], 1'b0);
  endtask

  function automatic logic [14:0] mkw(input int d, input logic [3:0] v);
    logic [7:0] s;
    s   = 8'h01 << d;
    mkw = {~gly[v], ~s};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] nv;
    logic [14:0] w;
    rst_n       = 1'b0;
    bus_if.ds   = 1'b0;
    bus_if.shcp = 1'b0;
    bus_if.stcp = 1'b0;
    nv          = 32'h1234ABCD;

    // Bus activity while in reset must be ignored.
    repeat (3) @(negedge clk);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    latch(15'h0, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_word",   32'(bus_if.word),        32'd0);
    check("rst_nums",   bus_if.nums,             32'd0);
    check("rst_dv",     32'(bus_if.digit_valid), 32'd0);
    check("rst_errlen", 32'(bus_if.err_len),     32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_on = 1'b1;

    // First word: 0x7F7F selects digit 7 with a blank segment pattern.
    send_bits(15'h7F7F, 15);
    latch(15'h7F7F, 1'b1);

    // Full frame for 0x1234ABCD.
    for (int d = 0; d < 8; d++) begin
      w = mkw(d, nv[d*4 +: 4]);
      send_bits(w, 15);
      latch(w, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("lit_frame_nums", bus_if.nums,             32'h1234ABCD);
    check("lit_frame_fd",   32'(fd_cnt),             32'd1);
    check("lit_frame_dv",   32'(bus_if.digit_valid), 32'd0);

    // Length error: 14 shifts leave bit 0 of 0x797F on top of 14 bits of 0x21FE.
    send_bits(15'h21FE, 14);
    latch(15'h61FE, 1'b1);
    send_bits(15'h21FE, 15);
    latch(15'h21FE, 1'b1);
    repeat (10) @(negedge clk);
    check("lit_len_cnt", 32'(el_cnt),             32'd1);
    check("lit_len_dv",  32'(bus_if.digit_valid), 32'h01);

    // Select error: two digits are active.
    w = {~gly[3], 8'hF3};
    send_bits(w, 15);
    latch(w, 1'b1);
    repeat (10) @(negedge clk);
    check("lit_sel_cnt",  32'(es_cnt),             32'd1);
    check("lit_sel_nums", bus_if.nums,             32'h1234ABCD);
    check("lit_sel_dv",   32'(bus_if.digit_valid), 32'h01);

    // Segment error: blank pattern on digit 2.
    send_bits(15'h7FFB, 15);
    latch(15'h7FFB, 1'b1);
    repeat (10) @(negedge clk);
    check("lit_seg_cnt",  32'(eg_cnt),             32'd3);
    check("lit_seg_nums", bus_if.nums,             32'h1234ABCD);
    check("lit_seg_dv",   32'(bus_if.digit_valid), 32'h01);

    // Simultaneous edges: 0x46FD (digit 1 'C') latches while bit 14 of 0x08F7 shifts in.
    send_bits(15'h46FD, 15);
    shift_bit(1'b0, 1'b1);
    send_bits(15'h08F7, 14);
    latch(15'h08F7, 1'b1);
    repeat (10) @(negedge clk);
    check("lit_sim_len",  32'(el_cnt),             32'd1);
    check("lit_sim_dv",   32'(bus_if.digit_valid), 32'h0B);
    check("lit_sim_nums", bus_if.nums,             32'h1234ABCD);

    repeat (20) @(negedge clk);
    check("pending_events", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/hc595_frame_rx.md
Name: hc595_frame_rx

Overview:
Receive-side counterpart of the HC595 display transmitter. It oversamples the three-wire 74HC595 bus (ds, shcp, stcp) with the system clock and rebuilds each latched 15-bit word {led[6:0], sel[7:0]}. It then decodes the 7-segment pattern back to a hex nibble and writes it into the digit slot selected by sel, recovering the 32-bit nums value that drove the display. It is used for display loopback self-test and as a synthesizable bus monitor.

Parameters:
WORD_W, 15, bits per latched word (fixed frame: led in the upper 7 bits, sel in the lower 8).
SEL_ACTIVE_LOW, 1, 1 = digit select is one-hot active-low on the wire; 0 = active-high.
SEG_ACTIVE_LOW, 1, 1 = segment bits are active-low (common anode); 0 = active-high.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ds  in  1  serial data, asynchronous to clk
shcp  in  1  shift clock, asynchronous to clk
stcp  in  1  storage/latch clock, asynchronous to clk
word  out  15  last latched word {led, sel}
word_valid  out  1  one-cycle pulse when word updates
nums  out  32  recovered value; digit i occupies nums[4i+3:4i]
digit_valid  out  8  bit i set once digit i has been decoded since reset or since the last frame_done
frame_done  out  1  one-cycle pulse when all 8 digit_valid bits are set; digit_valid clears the next cycle
err_len  out  1  one-cycle pulse: latch seen with bit count != 15
err_sel  out  1  one-cycle pulse: latched sel is not one-hot after polarity correction
err_seg  out  1  one-cycle pulse: segment pattern is not a legal hex glyph

Behaviour:
- Reset (async, rst_n=0): all outputs 0, shift register 0, bit count 0, synchronizers 0.
- ds, shcp and stcp each pass through a 2-FF synchronizer. Rising edges are detected on the synchronized shcp and stcp, comparing the current sample against the previous one.
- Input timing requirements: shcp high ≥3 clk and low ≥3 clk; ds stable from 2 clk before to 2 clk after each shcp rise. Behaviour outside these limits is undefined.
- Shift on a shcp rise:
  - sr <= {sr[13:0], ds_sync}, so the MSB is sent first.
  - bit count increments and saturates at 31.
- Latch on a stcp rise:
  - word <= sr (the pre-shift contents) and word_valid pulses.
  - err_len pulses if bit count != 15.
  - bit count resets to 0.
  - Latency: word_valid is high 3 clk after the raw stcp rise (2 synchronizer cycles + 1 register cycle).
- Simultaneous shcp and stcp rise in the same cycle: word latches the pre-shift sr, the shift still happens, and bit count is set to 1. This matches the real 595, where the storage register captures the old shift-register contents.
- Decode, one cycle after word_valid:
  - Polarity: sel_n = SEL_ACTIVE_LOW ? ~word[7:0] : word[7:0]; seg = SEG_ACTIVE_LOW ? ~word[14:8] : word[14:8], with seg bit order {g,f,e,d,c,b,a}.
  - Glyph table (0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - sel_n not one-hot (including zero): err_sel pulses and nums/digit_valid are unchanged.
  - sel_n one-hot at index i, seg not in the table: err_seg pulses and nums is unchanged.
  - sel_n one-hot at index i, seg legal: nums[4i+3:4i] <= glyph index and digit_valid[i] <= 1.
  - Total latency: 4 clk from the raw stcp rise to the nums update.
- frame_done: asserted combinationally from registered state the cycle digit_valid == 8'hFF. The following cycle digit_valid <= 0. nums holds its value.
- nums is never cleared except by reset.
- Errors do not block later frames.

Optional Feature:
HC595_RX_GLITCH_FILTER_EN
- Defined: an edge on synchronized shcp or stcp is accepted only after the new level has been stable for 2 further clk. This adds 2 clk to every latency above, and the minimum shcp high/low becomes 5 clk. Pulses shorter than 3 synchronized clk are ignored entirely.
- Undefined: raw edge detection as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 during bus activity → all outputs 0; release, then send 15 bits of 0x7F7F with stcp → word=0x7F7F and word_valid pulses exactly 3 clk after the stcp rise.
- Full frame, both polarity params =1: send 8 words encoding nums=0x1234ABCD, with digit i's glyph active-low and sel=~(1<<i) → nums=0x1234ABCD, frame_done pulses once, digit_valid returns to 0.
- Length error: 14 shifts then stcp → err_len pulse and word = the 15-bit sr contents. A following correct 15-bit word → no error.
- Select error: sel wire = 0xF3 (two digits active after inversion) → err_sel pulses; nums and digit_valid are unchanged.
- Segment error: legal sel with seg pattern 0x00 active-high (wire 0x7F) → err_seg pulses; that digit is not updated.
- Simultaneous edges: shcp and stcp rise together after 15 shifts → word = the pre-shift 15 bits and bit count = 1. The next 14 shifts plus stcp → no err_len.
